// File: rtl/pipeline_stage_reg.sv
// Inter-stage pipeline register: valid/ready handshake with a one-entry skid buffer,
// synchronous flush, zero-control bubbles and a saturating back-pressure counter.
module pipeline_stage_reg #(
    parameter int CTRL_W    = 16,
    parameter int PAYLOAD_W = 92,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CTRL_W-1:0]    in_ctrl,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CTRL_W-1:0]    out_ctrl,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [CNT_W-1:0]     stall_count,
    input  logic                 clr_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [CTRL_W-1:0]    m_ctrl, s_ctrl;
    logic [PAYLOAD_W-1:0] m_payload, s_payload;

    logic transfer_in, transfer_out;
    logic load_m, load_s, m_from_skid;

    // Handshake outputs come from registered state only, so no combinational
    // path exists from in_valid or out_ready to either ready/valid.
    assign out_valid    = (state != EMPTY);
    assign in_ready     = (state != FULL) && reset;
    assign transfer_in  = in_valid && in_ready;
    assign transfer_out = out_valid && out_ready;

    // Bubble insertion: an invalid slot must look like a no-op to the next stage.
    assign out_ctrl    = out_valid ? m_ctrl    : '0;
    assign out_payload = out_valid ? m_payload : '0;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path through
        // the case statement can leave one unassigned and infer a latch.
        state_next  = state;
        load_m      = 1'b0;
        load_s      = 1'b0;
        m_from_skid = 1'b0;
        unique case (state)
            EMPTY: begin
                if (transfer_in) begin
                    load_m     = 1'b1;
                    state_next = ONE;
                end
            end
            ONE: begin
                if (transfer_in && transfer_out) begin
                    load_m = 1'b1;
                end else if (transfer_out) begin
                    state_next = EMPTY;
                end else if (transfer_in) begin
                    load_s     = 1'b1;
                    state_next = FULL;
                end
            end
            FULL: begin
                if (transfer_out) begin
                    load_m      = 1'b1;
                    m_from_skid = 1'b1;
                    state_next  = ONE;
                end
            end
            default: state_next = EMPTY;
        endcase
        if (flush) begin
            state_next = EMPTY;
            load_m     = 1'b0;
            load_s     = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of the order of statements.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: the entry storage is reset and flushed to zero deliberately, so no
    // stale payload can surface if a later change relaxes the output gating.
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            m_ctrl    <= '0;
            m_payload <= '0;
            s_ctrl    <= '0;
            s_payload <= '0;
        end else begin
            if (load_m) begin
                m_ctrl    <= m_from_skid ? s_ctrl    : in_ctrl;
                m_payload <= m_from_skid ? s_payload : in_payload;
            end
            if (load_s) begin
                s_ctrl    <= in_ctrl;
                s_payload <= in_payload;
            end
        end
    end

    // Clear beats increment; flush has no effect on the statistic.
    always_ff @(posedge clk) begin
        if (!reset || clr_count) begin
            stall_count <= '0;
        end else if (out_valid && !out_ready && (stall_count != {CNT_W{1'b1}})) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule
